alu_multiciclo: RTL
===================

# alu_multiciclo

Parametrised successor to the single-cycle datapath ALU. It adds registered outputs, a start/pronto handshake, signed overflow and signed SLT, and iterative unsigned multiply/divide writing HI/LO registers. It sits in the EX stage of the multi-cycle processor; the control unit holds the instruction in EX while `busy` is high.

## Interface
- `WIDTH`, default 32: operand, result and HI/LO width; must be ≥ 4.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  operation request; sampled only when `busy`=0.
- `operacao`  in  4  operation code, same encoding as the ALU control unit.
- `data1`  in  WIDTH  operand A.
- `data2`  in  WIDTH  operand B.
- `alu_resultado`  out  WIDTH  registered result.
- `zero`  out  1  registered; 1 when `alu_resultado`=0.
- `overflow`  out  1  registered; signed overflow for ADD/SUB, else 0.
- `busy`  out  1  multi-cycle operation in progress.
- `pronto`  out  1  one-cycle pulse when the result is valid.
- `div_zero`  out  1  registered; 1 when the last DIVU had `data2`=0.
- `hi`, `lo`  out  WIDTH  product/remainder and quotient registers.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed; result 1 or 0), 1100 NOR, 0011 XOR: single-cycle.
  - 1000 MULTU: shift-add, one bit per cycle. {hi,lo} = data1×data2.
  - 1001 DIVU: restoring division, one bit per cycle. lo = quotient, hi = remainder.
  - Any other code: single-cycle, result 0.
- FSM states: OCIOSO, MUL, DIV.
  - OCIOSO → MUL / DIV when start=1 and the opcode is 1000 / 1001. Operands and opcode are latched at that edge.
  - MUL/DIV → OCIOSO when the iteration counter reaches WIDTH.
- Counter width is clog2(WIDTH)+1; it resets to 0 on every accept.
- A single-cycle op accepted in OCIOSO stays in OCIOSO. At the accept edge it updates alu_resultado, zero, overflow and pulses pronto.
- MULTU/DIVU completion:
  - alu_resultado = lo; zero = (lo==0); overflow = 0.
  - hi and lo update only at completion. Internal partials are kept in separate shadow registers, so the visible hi/lo hold their old values while busy.
- DIVU with data2 = 0:
  - No iteration; completes like a single-cycle op.
  - lo = all ones, hi = data1, div_zero = 1.
  - Any other accepted op clears div_zero.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operand signs compatible and result sign differs (ADD: equal signs; SUB: differing signs).
  - SLT compares as signed two's complement and never sets overflow.
- start while busy=1 is ignored; no queueing.
- All outputs hold their value until the next accepted op completes.
- Reset values: alu_resultado, hi, lo = 0; zero = 1; overflow, busy, pronto, div_zero = 0; FSM = OCIOSO.
- Reset mid-operation aborts the operation. hi/lo return to 0 and no pronto is produced.

## Timing
- Accept edge = edge N, with start=1 and busy=0.
- Single-cycle ops (including DIVU by zero): results and pronto=1 are visible after edge N. pronto drops after edge N+1 unless a new op is accepted at N+1, which allows back-to-back throughput of 1/cycle.
- MULTU/DIVU:
  - busy=1 from after edge N until after edge N+WIDTH.
  - At edge N+WIDTH, busy falls, pronto=1 for one cycle, and hi/lo/alu_resultado update.
  - Latency is WIDTH cycles.
- A new start is accepted at edge N+WIDTH+1 at the earliest.
- pronto is never high while busy is high.
- Inputs other than start are don't-care while busy=1.

## Test plan
- Reset, then ADD 7+5 (WIDTH=32) at edge N → alu_resultado=12, zero=0, pronto=1 only in cycle N+1. Then SUB 9−9 back-to-back → result 0, zero=1, pronto high two consecutive cycles.
- ADD 0x7FFFFFFF+1 → 0x80000000, overflow=1. SUB 0x80000000−1 → 0x7FFFFFFF, overflow=1. SLT 0xFFFFFFFF,1 → 1, overflow=0. Opcode 1111 → 0, zero=1.
- MULTU 0xFFFFFFFF×2 → busy for exactly 32 cycles; start pulses during busy are ignored; then hi=1, lo=0xFFFFFFFE, alu_resultado=0xFFFFFFFE, single pronto pulse.
- DIVU 100/7 → after 32 cycles lo=14, hi=2, div_zero=0. DIVU 5/0 → one cycle, lo=0xFFFFFFFF, hi=5, div_zero=1. Next AND clears div_zero.
- Async reset asserted mid-way through a MULTU (cycle 10) → immediately busy=0, hi=lo=0, zero=1. No pronto follows; the next ADD after release behaves normally.
- WIDTH=8 build: MULTU 0xFF×0xFF → hi=0xFE, lo=0x01 after 8 cycles.

Source files
------------

// File: rtl/alu_multiciclo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_multiciclo
// Brief    : EX-stage ALU with registered outputs, start/pronto handshake and
//            iterative unsigned MULTU/DIVU writing HI/LO.
// Revision : 1.0
// ============================================================================
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operacao,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] alu_resultado,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             pronto,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_ITER = CW'(WIDTH);

  localparam logic [3:0] C_OP_AND   = 4'b0000;
  localparam logic [3:0] C_OP_OR    = 4'b0001;
  localparam logic [3:0] C_OP_ADD   = 4'b0010;
  localparam logic [3:0] C_OP_XOR   = 4'b0011;
  localparam logic [3:0] C_OP_SUB   = 4'b0110;
  localparam logic [3:0] C_OP_SLT   = 4'b0111;
  localparam logic [3:0] C_OP_MULTU = 4'b1000;
  localparam logic [3:0] C_OP_DIVU  = 4'b1001;
  localparam logic [3:0] C_OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    MUL    = 2'd1,
    DIV    = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh_hi;
  logic [WIDTH-1:0] r_sh_lo;
  logic [WIDTH-1:0] r_op_b;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [CW-1:0]    w_cnt_next;
  logic             w_last;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_div_rem_sh;
  logic [WIDTH:0]   w_div_trial;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;

  always_comb begin
    w_sum  = data1 + data2;
    w_diff = data1 - data2;
    w_res  = '0;
    w_ovf  = 1'b0;
    case (operacao)
      C_OP_AND: w_res = data1 & data2;
      C_OP_OR:  w_res = data1 | data2;
      C_OP_XOR: w_res = data1 ^ data2;
      C_OP_NOR: w_res = ~(data1 | data2);
      C_OP_ADD: begin
        w_res = w_sum;
        w_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (w_sum[WIDTH-1] != data1[WIDTH-1]);
      end
      C_OP_SUB: begin
        w_res = w_diff;
        w_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (w_diff[WIDTH-1] != data1[WIDTH-1]);
      end
      C_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      default:  w_res = '0;
    endcase
  end

  assign w_cnt_next = r_cnt + CW'(1);
  assign w_last     = (w_cnt_next == C_ITER);

  // Shift-add: sh_hi accumulates, sh_lo holds the unconsumed multiplier bits.
  assign w_mul_sum = {1'b0, r_sh_hi} + (r_sh_lo[0] ? {1'b0, r_op_b} : {(WIDTH+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_sh_lo[WIDTH-1:1]};

  // Restoring division: sh_hi is the partial remainder, sh_lo shifts dividend out / quotient in.
  assign w_div_rem_sh = {r_sh_hi, r_sh_lo[WIDTH-1]};
  assign w_div_trial  = w_div_rem_sh - {1'b0, r_op_b};
  assign w_div_rem    = w_div_trial[WIDTH] ? w_div_rem_sh[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
  assign w_div_quo    = {r_sh_lo[WIDTH-2:0], ~w_div_trial[WIDTH]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= OCIOSO;
      r_cnt         <= '0;
      r_sh_hi       <= '0;
      r_sh_lo       <= '0;
      r_op_b        <= '0;
      alu_resultado <= '0;
      zero          <= 1'b1;
      overflow      <= 1'b0;
      busy          <= 1'b0;
      pronto        <= 1'b0;
      div_zero      <= 1'b0;
      hi            <= '0;
      lo            <= '0;
    end else begin
      pronto <= 1'b0;
      case (r_state)
        OCIOSO: begin
          if (start) begin
            div_zero <= 1'b0;
            r_cnt    <= '0;
            r_sh_hi  <= '0;
            r_sh_lo  <= data1;
            r_op_b   <= data2;
            case (operacao)
              C_OP_MULTU: begin
                r_state <= MUL;
                busy    <= 1'b1;
              end
              C_OP_DIVU: begin
                if (data2 == '0) begin
                  lo            <= {WIDTH{1'b1}};
                  hi            <= data1;
                  alu_resultado <= {WIDTH{1'b1}};
                  zero          <= 1'b0;
                  overflow      <= 1'b0;
                  div_zero      <= 1'b1;
                  pronto        <= 1'b1;
                end else begin
                  r_state <= DIV;
                  busy    <= 1'b1;
                end
              end
              default: begin
                alu_resultado <= w_res;
                zero          <= (w_res == '0);
                overflow      <= w_ovf;
                pronto        <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          r_sh_hi <= w_mul_hi;
          r_sh_lo <= w_mul_lo;
          r_cnt   <= w_cnt_next;
          if (w_last) begin
            hi            <= w_mul_hi;
            lo            <= w_mul_lo;
            alu_resultado <= w_mul_lo;
            zero          <= (w_mul_lo == '0);
            overflow      <= 1'b0;
            busy          <= 1'b0;
            pronto        <= 1'b1;
            r_state       <= OCIOSO;
          end
        end
        DIV: begin
          r_sh_hi <= w_div_rem;
          r_sh_lo <= w_div_quo;
          r_cnt   <= w_cnt_next;
          if (w_last) begin
            hi            <= w_div_rem;
            lo            <= w_div_quo;
            alu_resultado <= w_div_quo;
            zero          <= (w_div_quo == '0);
            overflow      <= 1'b0;
            busy          <= 1'b0;
            pronto        <= 1'b1;
            r_state       <= OCIOSO;
          end
        end
        default: begin
          r_state <= OCIOSO;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
